// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I front end: fetch FSM states, redirect
// kinds and the opcode values used by fetch, decode and immediate generation.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HOLD = 3'd2,
    ST_KILL = 3'd3,
    ST_TRAP = 3'd4
  } fetch_state_t;

  // Redirect kinds from execute; 2'b11 is reserved and behaves as a branch.
  localparam logic [1:0] RK_BRANCH = 2'b00;
  localparam logic [1:0] RK_JAL    = 2'b01;
  localparam logic [1:0] RK_JALR   = 2'b10;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/ifetch_target_calc.sv
// Redirect target computation: pc-relative for branch/jal, register-based
// for jalr with bit 0 cleared. Flags targets that are not word aligned.
module ifetch_target_calc
  import cpu_pkg::*;
(
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imm32,
  input  logic [31:0] rs1_data,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] base;
  logic [31:0] sum;

  // Select base, add immediate (mod 2^32), mask jalr bit 0, test alignment
  always_comb begin
    base       = (redirect_kind == RK_JALR) ? rs1_data : redirect_pc;
    sum        = base + imm32;
    target     = (redirect_kind == RK_JALR) ? {sum[31:1], 1'b0} : sum;
    misaligned = (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/ack
// handshake, buffers one instruction for decode and applies redirects
// from execute, discarding any response that belongs to a stale address.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imm32,
  input  logic [31:0] rs1_data,
  output logic        misalign
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  target;
  logic         target_misaligned;

  ifetch_target_calc u_target_calc (
    .redirect_kind (redirect_kind),
    .redirect_pc   (redirect_pc),
    .imm32         (imm32),
    .rs1_data      (rs1_data),
    .target        (target),
    .misaligned    (target_misaligned)
  );

  // Fetch FSM; redirect outranks ack and ready, and a request still in
  // flight when redirected is drained in KILL so its address never moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      inst_valid  <= 1'b0;
      instruction <= 32'd0;
      pc          <= RESET_PC;
      pc_plus4    <= RESET_PC + INST_BYTES;
      misalign    <= 1'b0;
    end else if (state == ST_TRAP) begin
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      fetch_pc   <= target;
      inst_valid <= 1'b0;
      if (target_misaligned) begin
        misalign <= 1'b1;
        imem_req <= 1'b0;
        state    <= ST_TRAP;
      end else if ((state == ST_REQ || state == ST_KILL) && !imem_ack) begin
        state <= ST_KILL;
      end else begin
        state     <= ST_REQ;
        imem_req  <= 1'b1;
        imem_addr <= target;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_REQ;
          imem_req  <= 1'b1;
          imem_addr <= fetch_pc;
        end
        ST_REQ: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            pc          <= fetch_pc;
            pc_plus4    <= fetch_pc + INST_BYTES;
            inst_valid  <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            fetch_pc   <= fetch_pc + INST_BYTES;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            imem_addr  <= fetch_pc + INST_BYTES;
            state      <= ST_REQ;
          end
        end
        ST_KILL: begin
          if (imem_ack) begin
            imem_addr <= fetch_pc;
            state     <= ST_REQ;
          end
        end
        default: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          state      <= ST_TRAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by randomized memory
// latency, ready and redirect traffic, all scored against a program-order
// model (expected next PC, word contents derived from the address).
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_pc;
  logic [31:0] imm32;
  logic [31:0] rs1_data;
  logic        misalign;

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .instruction   (instruction),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect),
    .redirect_kind (redirect_kind),
    .redirect_pc   (redirect_pc),
    .imm32         (imm32),
    .rs1_data      (rs1_data),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  // reference model: program-order view of the fetch stream
  logic [31:0] exp_pc;
  logic        mis_exp;
  logic        trapped;
  // memory responder and request tracking
  logic        busy;
  int          wait_cnt;
  int          lat_fix;
  logic        spur;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic check_reset_state();
    check32("rst_req",   imem_req,    0);
    check32("rst_addr",  imem_addr,   RESET_PC);
    check32("rst_valid", inst_valid,  0);
    check32("rst_inst",  instruction, 0);
    check32("rst_pc",    pc,          RESET_PC);
    check32("rst_pc4",   pc_plus4,    RESET_PC + 32'd4);
    check32("rst_mis",   misalign,    0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    repeat (2) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    exp_pc    = RESET_PC;
    mis_exp   = 1'b0;
    trapped   = 1'b0;
    busy      = 1'b0;
    wait_cnt  = 0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'd0;
    spur      = 1'b1;
  endtask

  task automatic set_redirect(input logic [1:0] k, input logic [31:0] rpc,
                              input logic [31:0] imm, input logic [31:0] rs1);
    redirect      = 1'b1;
    redirect_kind = k;
    redirect_pc   = rpc;
    imm32         = imm;
    rs1_data      = rs1;
  endtask

  task automatic random_redirect(input logic bad);
    logic [1:0]  k;
    logic [31:0] rpc, imm, rs1, s;
    k   = 2'($urandom_range(0, 3));
    rpc = $urandom & ~32'd3;
    imm = $urandom;
    rs1 = $urandom;
    if (bad) begin
      k = 2'b10;
      s = rs1 + imm;
      if (!s[1]) imm = imm + 32'd2;
    end else if (k == 2'b10) begin
      s = rs1 + imm;
      if (s[1]) imm = imm - 32'd2;
    end else begin
      imm = imm & ~32'd3;
    end
    set_redirect(k, rpc, imm, rs1);
  endtask

  // One clock: answer memory, score this cycle's events, advance the edge.
  task automatic tick();
    logic        start, xfer;
    logic [31:0] tgt;
    if (imem_req) begin
      if (!busy) begin
        busy     = 1'b1;
        wait_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end
      if (wait_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        busy       = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt--;
      end
    end else begin
      busy       = 1'b0;
      imem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
    end
    spur = 1'b0;

    start = imem_req && (!prev_req || prev_ack);
    if (imem_req && !start) check32("addr_stable", imem_addr, prev_addr);
    if (start) check32("req_addr", imem_addr, exp_pc);
    if (trapped) begin
      check32("trap_req",   imem_req,   0);
      check32("trap_valid", inst_valid, 0);
    end
    check32("misalign", misalign, mis_exp);

    xfer = inst_valid && inst_ready && !redirect && !trapped;
    if (xfer) begin
      check32("xfer_pc",   pc,          exp_pc);
      check32("xfer_inst", instruction, mem_word(exp_pc));
      check32("xfer_pc4",  pc_plus4,    exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (redirect && !trapped) begin
      if (redirect_kind == 2'b10) tgt = (rs1_data + imm32) & ~32'd1;
      else                        tgt = redirect_pc + imm32;
      exp_pc = tgt;
      if (tgt[1:0] != 2'b00) begin
        trapped = 1'b1;
        mis_exp = 1'b1;
      end
    end

    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  initial begin
    logic [31:0] hold_pc, hold_inst;
    logic        saw_valid;
    int          trap_wait;

    rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0;
    redirect_kind = 2'b00; redirect_pc = 32'd0; imm32 = 32'd0; rs1_data = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    lat_fix = 0;

    // zero-wait memory, always ready: one instruction every two cycles
    do_reset();
    check_reset_state();
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check32("thru_valid", inst_valid, 32'(i % 2));
      if (i % 2 == 1) begin
        check32("thru_pc",  pc,       32'((i / 2) * 4));
        check32("thru_pc4", pc_plus4, 32'((i / 2) * 4 + 4));
      end
    end

    // decode stalls five cycles in HOLD
    inst_ready = 1'b0;
    hold_pc    = pc;
    hold_inst  = instruction;
    repeat (5) begin
      tick();
      check32("stall_valid", inst_valid,  1);
      check32("stall_pc",    pc,          hold_pc);
      check32("stall_inst",  instruction, hold_inst);
      check32("stall_req",   imem_req,    0);
    end
    inst_ready = 1'b1;
    tick();
    check32("stall_next_req",  imem_req,  1);
    check32("stall_next_addr", imem_addr, hold_pc + 32'd4);

    // branch redirect in HOLD with ready high: buffer flushed
    inst_ready = 1'b0;
    tick();
    set_redirect(2'b00, 32'h100, 32'hFFFF_FFF0, 32'd0);
    inst_ready = 1'b1;
    tick();
    check32("br_valid", inst_valid, 0);
    check32("br_addr",  imem_addr,  32'hF0);
    tick();
    check32("br_pc", pc, 32'hF0);

    // jal while a 3-cycle request at 0x24 is in flight
    set_redirect(2'b01, 32'h0, 32'h24, 32'd0);
    lat_fix = 2;
    tick();
    check32("jal_addr0", imem_addr, 32'h24);
    set_redirect(2'b01, 32'h20, 32'h40, 32'd0);
    tick();
    saw_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (imem_req && imem_addr != 32'h24) break;
      saw_valid |= inst_valid;
      tick();
    end
    check32("kill_no_valid", saw_valid, 0);
    check32("kill_next",     imem_addr, 32'h60);

    // misaligned jalr traps until reset
    lat_fix = 0;
    set_redirect(2'b10, 32'h0, 32'h2, 32'h1001);
    tick();
    check32("trap_mis", misalign, 1);
    check32("trap_req0", imem_req, 0);
    repeat (5) tick();
    check32("trap_req5", imem_req, 0);
    do_reset();
    check_reset_state();
    tick();
    check32("post_trap_addr", imem_addr, RESET_PC);

    // jalr whose raw sum is odd but lands word aligned
    set_redirect(2'b10, 32'h0, 32'h5, 32'h1000);
    tick();
    check32("jalr_odd_mis",  misalign,  0);
    check32("jalr_odd_addr", imem_addr, 32'h1004);

    // redirect on the ack cycle, then fetch across the top of memory
    set_redirect(2'b01, 32'hFFFF_FFF0, 32'hC, 32'd0);
    tick();
    check32("ackred_valid", inst_valid, 0);
    check32("ackred_addr",  imem_addr,  32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    check32("wrap_pc",  pc,       32'hFFFF_FFFC);
    check32("wrap_pc4", pc_plus4, 32'h0);
    tick();
    check32("wrap_addr", imem_addr, 32'h0);

    // randomized traffic
    lat_fix   = -1;
    trap_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      if (trapped) begin
        trap_wait++;
        if (trap_wait > 4) begin
          trap_wait = 0;
          do_reset();
          check_reset_state();
        end
      end else if ($urandom_range(0, 499) == 0) begin
        do_reset();
        check_reset_state();
      end
      if ($urandom_range(0, 15) == 0) random_redirect($urandom_range(0, 11) == 0);
      tick();
    end
    check32("progress", 32'(n_xfer > 200), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the RV32I core: holds the PC, issues word fetches to instruction memory over a req/ack handshake, and presents instruction + PC to decode with a valid/ready handshake.
- Consumes the sign-extended imm32 produced by the immediate generator. Computes branch/jal/jalr redirect targets and flushes in-flight fetches on redirect.
- Sits directly upstream of decode/immediate generation and downstream of execute's branch resolution.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (must be word aligned).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  byte address of the fetch; stable while imem_req high.
- imem_ack  in  1  response valid; legal in any cycle imem_req is high, including the first.
- imem_rdata  in  32  instruction word, valid when imem_ack high.
- inst_valid  out  1  instruction/pc outputs valid.
- inst_ready  in  1  decode accepts this cycle.
- instruction  out  32  fetched instruction word.
- pc  out  32  address of instruction.
- pc_plus4  out  32  pc + 4 (jal/jalr link value).
- redirect  in  1  execute resolved a taken branch, jal or jalr this cycle.
- redirect_kind  in  2  00 branch, 01 jal, 10 jalr, 11 reserved (treated as branch).
- redirect_pc  in  32  pc of the redirecting instruction.
- imm32  in  32  sign-extended immediate of the redirecting instruction.
- rs1_data  in  32  rs1 value, used for jalr only.
- misalign  out  1  sticky: redirect target not word aligned.

Behaviour:
- Reset: state IDLE, fetch_pc=RESET_PC; imem_req=0, imem_addr=RESET_PC, inst_valid=0, instruction=0, pc=RESET_PC, pc_plus4=RESET_PC+4, misalign=0. Reset mid-request abandons it; any later ack is ignored until imem_req is next raised.
- Target calculation, all arithmetic mod 2^32:
  - branch/jal: redirect_pc + imm32.
  - jalr: (rs1_data + imm32) with bit0 forced to 0.
- States:
  - IDLE: 1 cycle after reset, then REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc. On ack: capture imem_rdata, pc=fetch_pc, pc_plus4=fetch_pc+4; inst_valid=1 next cycle; go HOLD.
  - HOLD: inst_valid=1 and outputs frozen until inst_ready. On transfer: fetch_pc+=4, inst_valid=0 next cycle, go REQ.
  - KILL: imem_req held high at the old address until ack; response discarded; then REQ at fetch_pc (already the target).
  - TRAP: imem_req=0, inst_valid=0; left only by rst.
- Throughput: one instruction per 2 cycles with zero-wait memory (ack in first req cycle, ready=1).
- Redirect has priority over every other event:
  - In REQ without ack: fetch_pc<=target, go KILL; the address does not change mid-request.
  - In REQ with ack in the same cycle: response discarded; fetch_pc<=target; REQ next cycle with new address.
  - In HOLD: buffer flushed even if inst_ready=1 the same cycle (no transfer counted); inst_valid=0 next cycle; fetch_pc<=target; go REQ.
  - In KILL: fetch_pc<=new target; stay in KILL.
  - In IDLE: fetch_pc<=target; go REQ.
- Misalignment: target[1:0]!=0 after jalr masking sets misalign=1 and enters TRAP on the next edge. It does not fire for an aligned jalr whose raw sum had bit0 set.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- imem_rdata is ignored whenever imem_ack=0.

Decomposition:
- Shared package cpu_pkg holds:
  - FSM state encoding: IDLE, REQ, HOLD, KILL, TRAP.
  - Redirect kind constants: RK_BRANCH, RK_JAL, RK_JALR.
  - Opcode constants shared with the immediate generator and decode: 7'b1100011, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0010111.
- One combinational sub-module, ifetch_target_calc: inputs redirect_kind, redirect_pc, imm32, rs1_data; outputs target and misaligned.

Test Plan:
- Reset then zero-wait memory, inst_ready=1: fetches at 0x0, 0x4, 0x8; inst_valid every other cycle; pc_plus4 = 0x4, 0x8, 0xC.
- inst_ready=0 for 5 cycles while HOLD: instruction/pc stable, imem_req=0; ready=1 -> next imem_addr=pc+4.
- Branch redirect in HOLD, redirect_pc=0x100, imm32=0xFFFF_FFF0: held instruction dropped; next imem_addr=0xF0; no transfer counted.
- Redirect (jal, redirect_pc=0x20, imm32=0x40) during a 3-cycle-latency request at 0x24:
  - imem_addr stays 0x24 until ack.
  - That response is never valid.
  - Next request is at 0x60.
- jalr rs1_data=0x1001, imm32=0x2: target 0x1002, misalign=1, TRAP; imem_req stays 0 until rst; rst restores RESET_PC fetch.
- Redirect with ack in the same REQ cycle, plus fetch_pc=0xFFFF_FFFC wrap case: stale word discarded; sequential fetch after 0xFFFF_FFFC is 0x0.
